// File: rtl/sram_ctrl.sv
// sram_ctrl: turns single-beat valid/ready read/write requests into
// SRAM bus cycles. The sequence is setup, a strobe of ACCESS_CYCLES
// cycles, then one recover cycle. Every strobe and the bus-drive enable
// is registered, so no req_* input reaches sram_* through logic alone.
module sram_ctrl #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data
);

    // The strobe counter counts down from ACCESS_CYCLES-1 to 0.
    localparam logic [3:0] CntLoad = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StRecover
    } state_e;

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic                is_write_q;
    logic                drive_q;
    logic [DATA_W-1:0]   wdata_q;

    // The bus is driven only from a registered enable. That enable is set
    // for writes only, so the bus can never be driven while oe is low.
    assign sram_data = drive_q ? wdata_q : {DATA_W{1'bz}};

    // Single FSM register block. It holds the state and every registered
    // output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            drive_q    <= 1'b0;
            wdata_q    <= '0;
            sram_cs    <= 1'b1;
            sram_oe    <= 1'b1;
            sram_we    <= 1'b1;
            sram_addr  <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            busy       <= 1'b0;
        end else begin
            // The response is a single-cycle pulse. It is set only on the
            // edge that leaves ACCESS for a read.
            rsp_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        state_q    <= StSetup;
                        sram_cs    <= 1'b0;
                        sram_addr  <= req_addr;
                        wdata_q    <= req_wdata;
                        is_write_q <= req_we;
                        drive_q    <= req_we;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                    end else begin
                        // This branch also raises ready on the first edge
                        // after reset is released.
                        req_ready <= 1'b1;
                    end
                end
                StSetup: begin
                    state_q <= StAccess;
                    cnt_q   <= CntLoad;
                    sram_we <= ~is_write_q;
                    sram_oe <= is_write_q;
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StRecover;
                        sram_we <= 1'b1;
                        sram_oe <= 1'b1;
                        if (!is_write_q) begin
                            rsp_rdata <= sram_data;
                            rsp_valid <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StRecover: begin
                    // Write data and the address stay valid through this
                    // cycle to cover the SRAM hold time.
                    state_q   <= StIdle;
                    sram_cs   <= 1'b1;
                    drive_q   <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Bus-safety properties that must hold whenever the block is out of reset.
    a_no_oe_we_overlap : assert property (@(posedge clk) disable iff (!rst_n)
        !(!sram_oe && !sram_we));
    a_no_drive_on_read : assert property (@(posedge clk) disable iff (!rst_n)
        !(!sram_oe && drive_q));
    a_ready_only_idle  : assert property (@(posedge clk) disable iff (!rst_n)
        !(req_ready && busy));

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: self-checking bench for sram_ctrl.
// Instance 0 uses ACCESS_CYCLES=2 and instance 1 uses ACCESS_CYCLES=1.
// Each instance is connected to a small behavioural SRAM. An undriven bus
// is pulled up, so a released bus reads back as all ones.
module tb_sram_ctrl;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [1:0]        req_valid, req_we, req_ready, rsp_valid, busy, cs, oe, we;
    logic [15:0]       req_addr  [2];
    logic [7:0]        req_wdata [2];
    logic [7:0]        rsp_rdata [2];
    logic [15:0]       sram_addr [2];
    wire  [7:0]        sd0, sd1;

    logic [7:0]        mem0 [65536];
    logic [7:0]        mem1 [65536];
    logic [7:0]        ref0 [logic [15:0]];
    logic [7:0]        ref1 [logic [15:0]];
    logic [7:0]        expq0 [$];
    logic [7:0]        expq1 [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    sram_ctrl #(.ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .sram_cs(cs[0]), .sram_oe(oe[0]), .sram_we(we[0]), .sram_addr(sram_addr[0]),
        .sram_data(sd0)
    );

    sram_ctrl #(.ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .sram_cs(cs[1]), .sram_oe(oe[1]), .sram_we(we[1]), .sram_addr(sram_addr[1]),
        .sram_data(sd1)
    );

    // Behavioural SRAMs. Reads are asynchronous while cs and oe are low.
    // A write is captured mid-cycle while cs and we are low.
    pullup pu0 (sd0);
    pullup pu1 (sd1);
    assign sd0 = (!cs[0] && !oe[0]) ? mem0[sram_addr[0]] : 8'hzz;
    assign sd1 = (!cs[1] && !oe[1]) ? mem1[sram_addr[1]] : 8'hzz;

    function automatic logic [7:0] init_pat(logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hC3;
    endfunction

    function automatic logic [7:0] bus(int i);
        return (i == 0) ? sd0 : sd1;
    endfunction

    function automatic logic [7:0] memrd(int i, logic [15:0] a);
        return (i == 0) ? mem0[a] : mem1[a];
    endfunction

    // Reference memory: the last value written, else the power-up pattern.
    function automatic logic [7:0] ref_rd(int i, logic [15:0] a);
        if (i == 0) return ref0.exists(a) ? ref0[a] : init_pat(a);
        return ref1.exists(a) ? ref1[a] : init_pat(a);
    endfunction

    function automatic void ref_wr(int i, logic [15:0] a, logic [7:0] d);
        if (i == 0) ref0[a] = d;
        else ref1[a] = d;
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem0[a] = init_pat(16'(a));
            mem1[a] = init_pat(16'(a));
        end
    end

    // SRAM write capture, plus a scoreboard and bus-rule monitor that
    // sample on the falling edge.
    always @(negedge clk) begin
        if (!cs[0] && !we[0]) mem0[sram_addr[0]] = sd0;
        if (!cs[1] && !we[1]) mem1[sram_addr[1]] = sd1;
        for (int i = 0; i < 2; i++) begin
            if (rst_n && req_valid[i] && req_ready[i]) begin
                if (req_we[i]) ref_wr(i, req_addr[i], req_wdata[i]);
                else if (i == 0) expq0.push_back(ref_rd(0, req_addr[0]));
                else expq1.push_back(ref_rd(1, req_addr[1]));
            end
            if (rsp_valid[i]) begin
                if (i == 0 && expq0.size() > 0) chk("sb_rsp_data0", 32'(rsp_rdata[0]), 32'(expq0.pop_front()));
                else if (i == 1 && expq1.size() > 0) chk("sb_rsp_data1", 32'(rsp_rdata[1]), 32'(expq1.pop_front()));
                else chk("sb_unexpected_rsp", 32'(rsp_valid[i]), 32'd0);
            end
            chk("oe_we_overlap", 32'(!oe[i] && !we[i]), 32'd0);
            chk("ready_while_busy", 32'(req_ready[i] && busy[i]), 32'd0);
            if (cs[i]) chk("bus_released_idle", 32'(bus(i)), 32'hFF);
            if (!oe[i]) chk("bus_read_no_drive", 32'(bus(i)), 32'(memrd(i, sram_addr[i])));
        end
    end

    // One full request on instance i. The checks cover handshake timing,
    // strobe length, address and data on the bus, and read latency/data.
    task automatic do_req(input int i, input logic w, input logic [15:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rd);
        int ac;
        int k;
        int first_ready;
        int n_strobe;
        int n_rsp;
        int rsp_cyc;
        ac = (i == 0) ? 2 : 1;
        k = 0;
        while (!req_ready[i] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (!req_ready[i]) begin
            chk("req_ready_timeout", 32'(req_ready[i]), 32'd1);
            return;
        end
        req_valid[i] = 1'b1;
        req_we[i]    = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        first_ready = -1;
        n_strobe = 0;
        n_rsp = 0;
        rsp_cyc = -1;
        // cyc counts the edges since the accept edge T.
        for (int cyc = 0; cyc <= ac + 2; cyc++) begin
            if (req_ready[i] && first_ready < 0) first_ready = cyc;
            if (w ? !we[i] : !oe[i]) begin
                n_strobe++;
                chk("strobe_addr", 32'(sram_addr[i]), 32'(a));
                if (w) chk("wr_bus_data", 32'(bus(i)), 32'(d));
            end
            if (rsp_valid[i]) begin
                n_rsp++;
                rsp_cyc = cyc;
                chk("rd_data", 32'(rsp_rdata[i]), 32'(exp_rd));
            end
            if (cyc < ac + 2) begin
                @(posedge clk); #1;
            end
        end
        chk("ready_low_cycles", 32'(first_ready), 32'(ac + 2));
        chk("strobe_len", 32'(n_strobe), 32'(ac));
        if (w) begin
            chk("wr_no_rsp", 32'(n_rsp), 32'd0);
        end else begin
            chk("rd_rsp_count", 32'(n_rsp), 32'd1);
            chk("rd_latency", 32'(rsp_cyc + 1), 32'(ac + 2));
        end
    endtask

    typedef struct {
        int          inst;
        logic        w;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int last;
        int acc;
        int k;
        tbl[0] = '{0, 1'b1, 16'h0001, 8'hAA, 8'h00};
        tbl[1] = '{0, 1'b0, 16'h0001, 8'h00, 8'hAA};
        tbl[2] = '{0, 1'b1, 16'h0002, 8'h55, 8'h00};
        tbl[3] = '{0, 1'b1, 16'hFFFF, 8'h3C, 8'h00};
        tbl[4] = '{0, 1'b0, 16'hFFFF, 8'h00, 8'h3C};
        tbl[5] = '{0, 1'b0, 16'h0002, 8'h00, 8'h55};
        tbl[6] = '{1, 1'b1, 16'h0010, 8'h5A, 8'h00};
        tbl[7] = '{1, 1'b0, 16'h0010, 8'h00, 8'h5A};

        req_valid = '0;
        req_we = '0;
        for (int i = 0; i < 2; i++) begin
            req_addr[i] = '0;
            req_wdata[i] = '0;
        end

        // Asynchronous reset. The values must be visible before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_strobes", 32'({cs[i], oe[i], we[i]}), 32'h7);
            chk("rst_ready", 32'(req_ready[i]), 32'd0);
            chk("rst_busy", 32'(busy[i]), 32'd0);
            chk("rst_rsp", 32'({rsp_valid[i], rsp_rdata[i]}), 32'd0);
            chk("rst_addr", 32'(sram_addr[i]), 32'd0);
        end
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        #1 chk("ready_before_edge", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_edge", 32'(req_ready), 32'h3);

        // Directed table.
        foreach (tbl[n]) do_req(tbl[n].inst, tbl[n].w, tbl[n].addr, tbl[n].wdata, tbl[n].rdata);

        // Back-to-back random traffic with req_valid held high.
        last = -1;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'($urandom_range(0, 1));
        req_addr[0]  = 16'h0100 + 16'($urandom_range(0, 7));
        req_wdata[0] = 8'($urandom);
        for (int n = 0; n < 40; n++) begin
            k = 0;
            while (!req_ready[0] && k < 12) begin
                @(posedge clk); #1;
                k++;
            end
            if (!req_ready[0]) begin
                chk("b2b_ready_timeout", 32'(req_ready[0]), 32'd1);
                break;
            end
            @(posedge clk); #1;
            acc = cyc_cnt;
            if (n > 0) chk("b2b_spacing", 32'(acc - last), 32'd5);
            last = acc;
            req_we[0]    = 1'($urandom_range(0, 1));
            req_addr[0]  = 16'h0100 + 16'($urandom_range(0, 7));
            req_wdata[0] = 8'($urandom);
        end
        req_valid[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("b2b_rsp_drained", 32'(expq0.size()), 32'd0);

        // Reset in the middle of the ACCESS phase of a write.
        do_req(0, 1'b0, 16'h0001, 8'h00, 8'hAA);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 16'h0077;
        req_wdata[0] = 8'h77;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_we_low", 32'(we[0]), 32'd0);
        chk("pre_rst_bus_driven", 32'(sd0), 32'h77);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_strobes", 32'({cs[0], oe[0], we[0]}), 32'h7);
        chk("abort_bus_released", 32'(sd0), 32'hFF);
        chk("abort_no_rsp", 32'(rsp_valid[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_ready", 32'(req_ready[0]), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1 chk("abort_ready_pre_edge", 32'(req_ready[0]), 32'd0);
        @(posedge clk); #1;
        chk("abort_ready_post_edge", 32'(req_ready[0]), 32'd1);
        chk("abort_rsp_none", 32'(rsp_valid[0]), 32'd0);

        // Operation resumes after the abort, on both instances.
        do_req(0, 1'b1, 16'h0003, 8'hC5, 8'h00);
        do_req(0, 1'b0, 16'h0003, 8'h00, 8'hC5);
        do_req(1, 1'b0, 16'h0010, 8'h00, 8'h5A);
        repeat (3) @(posedge clk);
        #1 chk("final_rsp_drained", 32'(expq0.size() + expq1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t, expected < 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
